// File: rtl/calc1_pkg.sv
// calc1_pkg: command/response codes and driver state shared by the calc1 port driver.
package calc1_pkg;
    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;
    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK = 2'd1;
    localparam logic [1:0] RESP_ERR = 2'd2;
    localparam logic [1:0] RESP_TMO = 2'd3;
    typedef enum logic [2:0] {S_IDLE, S_SEND1, S_SEND2, S_WAIT, S_HOLD} drv_state_t;
endpackage

// File: rtl/calc1_wait_timer.sv
// calc1_wait_timer: WAIT-cycle counter that flags expiry on its TIMEOUT-th cycle.
module calc1_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic c_clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT);
    logic [W-1:0] count;
    assign expire = count == W'(TIMEOUT - 1);
    always_ff @(posedge c_clk) begin
        if (reset || clear)
            count <= '0;
        else if (enable && !expire)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/calc1_port_driver.sv
// calc1_port_driver: serialises one request onto a calc1 port and returns the response,
// with a local timeout and local rejection of NOP commands.
module calc1_port_driver
    import calc1_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TAG_W = 2
) (
    input  logic             c_clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_cmd,
    input  logic [31:0]      req_op1,
    input  logic [31:0]      req_op2,
    input  logic [TAG_W-1:0] req_tag,
    output logic [3:0]       port_cmd,
    output logic [31:0]      port_data,
    input  logic [1:0]       port_resp,
    input  logic [31:0]      port_out_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_resp,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             stray_resp
);
    drv_state_t state;
    logic [31:0] op2;
    logic expire;
    assign req_ready = state == S_IDLE;
    calc1_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .c_clk (c_clk),
        .reset (reset),
        .clear (state != S_WAIT),
        .enable(state == S_WAIT),
        .expire(expire)
    );
    // Port outputs are loaded one state early so they are registered yet on time.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            state      <= S_IDLE;
            op2        <= '0;
            port_cmd   <= '0;
            port_data  <= '0;
            rsp_valid  <= 1'b0;
            rsp_resp   <= RESP_NONE;
            rsp_data   <= '0;
            rsp_tag    <= '0;
            stray_resp <= 1'b0;
        end else begin
            stray_resp <= state != S_WAIT && port_resp != RESP_NONE;
            case (state)
                S_IDLE: if (req_valid) begin
                    op2     <= req_op2;
                    rsp_tag <= req_tag;
                    if (req_cmd == CMD_NOP) begin
                        state     <= S_HOLD;
                        rsp_valid <= 1'b1;
                        rsp_resp  <= RESP_ERR;
                        rsp_data  <= '0;
                    end else begin
                        state     <= S_SEND1;
                        port_cmd  <= req_cmd;
                        port_data <= req_op1;
                    end
                end
                S_SEND1: begin
                    state     <= S_SEND2;
                    port_cmd  <= CMD_NOP;
                    port_data <= op2;
                end
                S_SEND2: begin
                    state     <= S_WAIT;
                    port_data <= '0;
                end
                S_WAIT: if (port_resp != RESP_NONE || expire) begin
                    state     <= S_HOLD;
                    rsp_valid <= 1'b1;
                    rsp_resp  <= port_resp != RESP_NONE ? port_resp : RESP_TMO;
                    rsp_data  <= port_resp != RESP_NONE ? port_out_data : '0;
                end
                S_HOLD: if (rsp_ready) begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_calc1_port_driver.sv
// tb_calc1_port_driver: table-driven and randomized checks of the calc1 port driver
// against a transaction-level calc1 responder model.
module tb_calc1_port_driver;
    localparam int TIMEOUT = 16;
    logic c_clk = 1'b0;
    logic reset, req_valid, req_ready, rsp_valid, rsp_ready, stray_resp;
    logic [3:0] req_cmd, port_cmd;
    logic [31:0] req_op1, req_op2, port_data, port_out_data, rsp_data;
    logic [1:0] req_tag, port_resp, rsp_resp, rsp_tag;
    int checks = 0;
    int errors = 0;

    calc1_port_driver #(.TIMEOUT(TIMEOUT), .TAG_W(2)) dut (
        .c_clk(c_clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_op1(req_op1), .req_op2(req_op2), .req_tag(req_tag),
        .port_cmd(port_cmd), .port_data(port_data), .port_resp(port_resp),
        .port_out_data(port_out_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_resp(rsp_resp), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .stray_resp(stray_resp)
    );

    always #5 c_clk = ~c_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural calc1: overflow, underflow and unknown commands answer error with zero data.
    function automatic void calc(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                 output logic [1:0] r, output logic [31:0] v);
        logic [32:0] s;
        r = 2'd1;
        v = 32'd0;
        s = {1'b0, a} + {1'b0, b};
        case (cmd)
            4'd1: if (s[32]) r = 2'd2; else v = s[31:0];
            4'd2: if (a < b) r = 2'd2; else v = a - b;
            4'd5: v = a << b[4:0];
            4'd6: v = a >> b[4:0];
            default: r = 2'd2;
        endcase
    endfunction

    // d = WAIT cycle index at which calc1 answers; d >= TIMEOUT means never.
    task automatic run_txn(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                           input logic [1:0] tag, input int d, input int hold,
                           input logic [1:0] exp_resp, input logic [31:0] exp_data);
        logic [1:0] pr;
        logic [31:0] pd;
        int lat, exp_lat;
        calc(cmd, op1, op2, pr, pd);
        exp_lat = cmd == 4'd0 ? 1 : (d < TIMEOUT ? 4 + d : 3 + TIMEOUT);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_cmd = cmd; req_op1 = op1; req_op2 = op2; req_tag = tag;
        @(negedge c_clk);
        req_valid = 1'b0;
        lat = 1;
        if (cmd == 4'd0) chk("nop_port_quiet", {port_cmd, port_data}, 0);
        while (!rsp_valid && lat < 60) begin
            if (lat == 1) chk("send1", {port_cmd, port_data}, {cmd, op1});
            else if (lat == 2) chk("send2", {port_cmd, port_data}, {4'd0, op2});
            else chk("wait_port_quiet", {port_cmd, port_data}, 0);
            port_resp = lat == 3 + d ? pr : 2'd0;
            port_out_data = lat == 3 + d ? pd : $urandom;
            @(negedge c_clk);
            port_resp = 2'd0;
            lat++;
        end
        chk("latency", lat, exp_lat);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_cmd = 4'd0; req_tag = ~tag;
            chk("hold_ready_low", req_ready, 0);
            chk("hold_fields", {rsp_valid, rsp_resp, rsp_data, rsp_tag}, {1'b1, exp_resp, exp_data, tag});
            @(negedge c_clk);
        end
        chk("rsp_fields", {rsp_valid, rsp_resp, rsp_data, rsp_tag}, {1'b1, exp_resp, exp_data, tag});
        rsp_ready = 1'b1;
        @(negedge c_clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("release_idle", {rsp_valid, req_ready}, 2'b01);
    endtask

    typedef struct {
        logic [3:0] cmd;
        logic [31:0] op1, op2;
        logic [1:0] tag;
        int d, hold;
        logic [1:0] exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    initial begin
        vec_t tbl[10];
        logic [3:0] cmds[7];
        logic [1:0] pr, er;
        logic [31:0] pd, ed;
        bit seen;
        cmds = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd7};
        tbl[0] = '{4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 2'd1, 2, 0, 2'd1, 32'h2000_0000};
        tbl[1] = '{4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 0, 0, 2'd2, 32'h0};
        tbl[2] = '{4'd0, 32'h1234_5678, 32'h9ABC_DEF0, 2'd3, 0, 0, 2'd2, 32'h0};
        tbl[3] = '{4'd2, 32'd10, 32'd3, 2'd0, 5, 1, 2'd1, 32'd7};
        tbl[4] = '{4'd5, 32'd1, 32'd4, 2'd1, 1, 5, 2'd1, 32'd16};
        tbl[5] = '{4'd1, 32'd2, 32'd3, 2'd2, 100, 0, 2'd3, 32'h0};
        tbl[6] = '{4'd1, 32'd2, 32'd3, 2'd3, TIMEOUT - 1, 0, 2'd1, 32'd5};
        tbl[7] = '{4'd6, 32'h8000_0000, 32'd31, 2'd0, TIMEOUT - 2, 2, 2'd1, 32'd1};
        tbl[8] = '{4'd3, 32'd9, 32'd9, 2'd1, 3, 0, 2'd2, 32'h0};
        tbl[9] = '{4'd2, 32'd3, 32'd10, 2'd2, TIMEOUT, 0, 2'd3, 32'h0};
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_cmd = '0; req_op1 = '0;
        req_op2 = '0; req_tag = '0; port_resp = '0; port_out_data = '0;
        repeat (3) @(negedge c_clk);
        reset = 1'b0;
        chk("reset_outputs", {port_cmd, port_data, rsp_valid, rsp_resp, rsp_data, rsp_tag, stray_resp}, 0);
        chk("reset_ready", req_ready, 1);
        foreach (tbl[i])
            run_txn(tbl[i].cmd, tbl[i].op1, tbl[i].op2, tbl[i].tag, tbl[i].d, tbl[i].hold,
                    tbl[i].exp_resp, tbl[i].exp_data);
        // Reset while waiting for calc1 drops the request entirely.
        req_valid = 1'b1; req_cmd = 4'd1; req_op1 = 32'd5; req_op2 = 32'd6; req_tag = 2'd2;
        @(negedge c_clk);
        req_valid = 1'b0;
        repeat (3) @(negedge c_clk);
        reset = 1'b1;
        @(negedge c_clk);
        reset = 1'b0;
        chk("midreset_outputs", {port_cmd, port_data, rsp_valid, rsp_resp, rsp_data, rsp_tag, stray_resp}, 0);
        chk("midreset_ready", req_ready, 1);
        seen = 1'b0;
        repeat (TIMEOUT + 4) begin
            @(negedge c_clk);
            seen |= rsp_valid;
        end
        chk("midreset_no_rsp", seen, 0);
        // Stray response in IDLE.
        port_resp = 2'd1; port_out_data = 32'hDEAD_BEEF;
        @(negedge c_clk);
        port_resp = 2'd0;
        chk("stray_pulse", {stray_resp, rsp_valid}, 2'b10);
        @(negedge c_clk);
        chk("stray_end", {stray_resp, rsp_valid, req_ready}, 3'b001);
        for (int n = 0; n < 40; n++) begin
            logic [3:0] c;
            logic [31:0] a, b;
            int d;
            c = cmds[$urandom_range(0, 6)];
            a = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 100);
            b = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 100);
            d = $urandom_range(0, TIMEOUT + 2);
            calc(c, a, b, pr, pd);
            er = c == 4'd0 ? 2'd2 : (d < TIMEOUT ? pr : 2'd3);
            ed = c != 4'd0 && d < TIMEOUT ? pd : 32'd0;
            run_txn(c, a, b, 2'($urandom), d, $urandom_range(0, 3), er, ed);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
